// File: rtl/histogram_cdf.sv
`timescale 1ns/1ps
// histogram_cdf: streams NBINS histogram bins in order and writes their running prefix sum (CDF) to a CDF RAM.
// Optional macro HIST_CLEAR_EN: zero each bin in the bin RAM two cycles after it has been read.
module histogram_cdf #(
    parameter int NBINS  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] total,
    output logic              overflow,
    output logic [ADDR_W-1:0] bin_raddr_0,
    input  logic [DATA_W-1:0] bin_rdata_0,
    output logic [ADDR_W-1:0] bin_waddr_0,
    output logic [DATA_W-1:0] bin_wdata_0,
    output logic              bin_wen_0,
    output logic [ADDR_W-1:0] cdf_waddr_0,
    output logic [DATA_W-1:0] cdf_wdata_0,
    output logic              cdf_wen_0
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NBINS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, raddr_q, raddr2_q, cdf_waddr_q;
    logic              rvld1_q, rvld2_q, cdf_wen_q;
    logic              busy_q, valid_q, overflow_q;
    logic [DATA_W-1:0] acc_q, total_q, cdf_wdata_q;
    logic [DATA_W:0]   sum;
    logic              accept;

    assign accept = (state_q == IDLE) && start;
    assign sum    = {1'b0, acc_q} + {1'b0, bin_rdata_0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN ends on the edge after the final CDF write has been presented.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DRAIN;
            DRAIN:   if (cdf_wen_q && (cdf_waddr_q == LAST)) state_d = DONE;
            DONE:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read pipeline: address issue, RAM latency stage, then accumulate and write the CDF word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            raddr_q     <= '0;
            raddr2_q    <= '0;
            rvld1_q     <= 1'b0;
            rvld2_q     <= 1'b0;
            acc_q       <= '0;
            overflow_q  <= 1'b0;
            cdf_wen_q   <= 1'b0;
            cdf_waddr_q <= '0;
            cdf_wdata_q <= '0;
            total_q     <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            busy_q    <= (state_d == RUN) || (state_d == DRAIN);
            valid_q   <= (state_d == DONE);
            rvld1_q   <= (state_q == RUN);
            rvld2_q   <= rvld1_q;
            raddr2_q  <= raddr_q;
            cdf_wen_q <= rvld2_q;
            if (accept) begin
                cnt_q      <= '0;
                acc_q      <= '0;
                overflow_q <= 1'b0;
            end
            if (state_q == RUN) begin
                raddr_q <= cnt_q;
                if (cnt_q != LAST) begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                end
            end
            if (rvld2_q) begin
                acc_q       <= sum[DATA_W-1:0];
                cdf_wdata_q <= sum[DATA_W-1:0];
                cdf_waddr_q <= raddr2_q;
                if (sum[DATA_W]) begin
                    overflow_q <= 1'b1;
                end
            end
            if ((state_q == DRAIN) && (state_d == DONE)) begin
                total_q <= acc_q;
            end
        end
    end

`ifdef HIST_CLEAR_EN
    logic              bin_wen_q;
    logic [ADDR_W-1:0] bin_waddr_q;

    // Zeroing a bin trails its read by two cycles, so the bin RAM must support read and write together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_wen_q   <= 1'b0;
            bin_waddr_q <= '0;
        end else begin
            bin_wen_q <= rvld2_q;
            if (rvld2_q) begin
                bin_waddr_q <= raddr2_q;
            end
        end
    end

    assign bin_wen_0   = bin_wen_q;
    assign bin_waddr_0 = bin_waddr_q;
    assign bin_wdata_0 = '0;
`else
    assign bin_wen_0   = 1'b0;
    assign bin_waddr_0 = '0;
    assign bin_wdata_0 = '0;
`endif

    assign busy        = busy_q;
    assign valid       = valid_q;
    assign total       = total_q;
    assign overflow    = overflow_q;
    assign bin_raddr_0 = raddr_q;
    assign cdf_wen_0   = cdf_wen_q;
    assign cdf_waddr_0 = cdf_waddr_q;
    assign cdf_wdata_0 = cdf_wdata_q;

endmodule
